// File: rtl/seq_frame_tx_pkg.sv
// rtl/seq_frame_tx_pkg.sv - shared state encodings, defaults and sizing helpers for seq_frame_tx
//
// Contents:
//   state_t       3-bit FSM state encoding (ST_IDLE/ST_SYNC/ST_DATA/ST_PARITY/ST_GAP)
//   DEFAULT_SYNC  default SYNC pattern (4'b1011 in the low bits)
//   clog2, max3   constant-elaboration helpers for counter sizing
package seq_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam logic [15:0] DEFAULT_SYNC = 16'h000B;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// rtl/seq_frame_tx_if.sv - parallel payload valid/ready handshake for seq_frame_tx
//
// Signals:
//   in_data   WIDTH  payload word (master -> slave)
//   in_valid  1      payload offered (master -> slave)
//   in_ready  1      slave can accept (slave -> master)
interface seq_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_frame_tx_piso.sv
// rtl/seq_frame_tx_piso.sv - WIDTH-bit parallel-in/serial-out shift register, MSB out
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-low reset (clears the register)
//   load   in   capture din (has priority over shift)
//   shift  in   shift left by one, zero fill
//   din    in   parallel word
//   msb    out  current MSB of the register
module seq_frame_tx_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst)       sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= sr << 1;
    end

    assign msb = sr[WIDTH-1];
endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: SYNC pattern, MSB-first payload, optional parity, idle gap
//
// Ports:
//   clk    in     clock, rising edge
//   rst    in     synchronous active-low reset
//   in_if  slave  payload handshake (in_data/in_valid in, in_ready out)
//   out    out    serial line, registered, low when idle or in gap
//   busy   out    high from the cycle after acceptance through the last gap cycle
//   done   out    high while the final frame bit is on out
// Build option: SEQ_TX_PARITY_EN appends an even-parity bit after the payload.
module seq_frame_tx
    import seq_frame_tx_pkg::*;
#(
    parameter int                  WIDTH      = 8,
    parameter int                  SYNC_LEN   = 4,
    parameter logic [SYNC_LEN-1:0] SYNC       = DEFAULT_SYNC[SYNC_LEN-1:0],
    parameter int                  GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    seq_frame_tx_if.slave in_if,
    output logic          out,
    output logic          busy,
    output logic          done
);
    // Gap length is folded into the sizing so the counter can also time the gap.
    localparam int CNT_MAX = max3(SYNC_LEN, WIDTH, GAP_CYCLES);
    localparam int CW      = clog2(CNT_MAX + 1);

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic                out_next;
    logic                load, shift, piso_msb;
    logic [SYNC_LEN-1:0] sync_rest;

    seq_frame_tx_piso #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (in_if.in_data),
        .msb   (piso_msb)
    );

`ifdef SEQ_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst)      parity_q <= 1'b0;
        else if (load) parity_q <= ^in_if.in_data;
    end
`endif

    // out is registered, so next-state logic decides the bit the line carries next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out   <= out_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        done       = 1'b0;
        // Pattern aligned so its MSB is the SYNC bit following the one now on the line.
        sync_rest  = SYNC << (cnt + CW'(1));
        case (state)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    state_next = ST_SYNC;
                    cnt_next   = '0;
                    out_next   = SYNC[SYNC_LEN-1];
                    load       = 1'b1;
                end
            end
            ST_SYNC: begin
                if (cnt == CW'(SYNC_LEN - 1)) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                    out_next   = piso_msb;
                    shift      = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                    out_next = sync_rest[SYNC_LEN-1];
                end
            end
            ST_DATA: begin
                if (cnt == CW'(WIDTH - 1)) begin
`ifdef SEQ_TX_PARITY_EN
                    state_next = ST_PARITY;
                    out_next   = parity_q;
`else
                    done       = 1'b1;
                    state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    cnt_next   = '0;
`endif
                end else begin
                    cnt_next = cnt + CW'(1);
                    out_next = piso_msb;
                    shift    = 1'b1;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: begin
                done       = 1'b1;
                state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                cnt_next   = '0;
            end
`endif
            ST_GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) state_next = ST_IDLE;
                else                            cnt_next   = cnt + CW'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_if.in_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - self-checking bench for seq_frame_tx (GAP_CYCLES=2 and GAP_CYCLES=0 instances)
//
// Two DUTs share clk/rst; each has its own handshake. A queue model holds the
// per-cycle line contents of every accepted frame and is compared every cycle;
// literal frame captures pin the model. Honours SEQ_TX_PARITY_EN.
module tb_seq_frame_tx;

`ifdef SEQ_TX_PARITY_EN
    localparam int FB = 13;
`else
    localparam int FB = 12;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } fr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  vld;
    logic [7:0]  dat [2];
    logic        out0, out1, busy0, busy1, done0, done1;
    logic [1:0]  o_out, o_busy, o_done, o_rdy;
    logic        chk_en = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cnt [2];
    int          acc_cyc [2];
    fr_t         q [2][$];

    always #5 clk = ~clk;

    seq_frame_tx_if #(.WIDTH(8)) if0 ();
    seq_frame_tx_if #(.WIDTH(8)) if1 ();

    assign if0.in_valid = vld[0];
    assign if0.in_data  = dat[0];
    assign if1.in_valid = vld[1];
    assign if1.in_data  = dat[1];

    seq_frame_tx #(.WIDTH(8), .SYNC_LEN(4), .SYNC(4'b1011), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .in_if(if0), .out(out0), .busy(busy0), .done(done0)
    );
    seq_frame_tx #(.WIDTH(8), .SYNC_LEN(4), .SYNC(4'b1011), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .in_if(if1), .out(out1), .busy(busy1), .done(done1)
    );

    assign o_out  = {out1, out0};
    assign o_busy = {busy1, busy0};
    assign o_done = {done1, done0};
    assign o_rdy  = {if1.in_ready, if0.in_ready};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Line contents of one frame, one entry per cycle, including the trailing gap.
    function automatic void push_frame(input int k, input logic [7:0] d);
        logic [3:0] sv;
        int         gap;
        sv  = 4'b1011;
        gap = (k == 0) ? 2 : 0;
        for (int i = 3; i >= 0; i--) q[k].push_back('{b: sv[i], last: 1'b0});
`ifdef SEQ_TX_PARITY_EN
        for (int i = 7; i >= 0; i--) q[k].push_back('{b: d[i], last: 1'b0});
        q[k].push_back('{b: ^d, last: 1'b1});
`else
        for (int i = 7; i >= 1; i--) q[k].push_back('{b: d[i], last: 1'b0});
        q[k].push_back('{b: d[0], last: 1'b1});
`endif
        for (int i = 0; i < gap; i++) q[k].push_back('{b: 1'b0, last: 1'b0});
    endfunction

    function automatic logic exp_out(input int k);
        if (q[k].size() == 0) return 1'b0;
        return q[k][0].b;
    endfunction

    function automatic logic exp_done(input int k);
        if (q[k].size() == 0) return 1'b0;
        return q[k][0].last;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                q[k].delete();
            end else if (q[k].size() == 0) begin
                if (vld[k]) begin
                    push_frame(k, dat[k]);
                    acc_cnt[k] <= acc_cnt[k] + 1;
                    acc_cyc[k] <= cyc;
                end
            end else begin
                void'(q[k].pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("out%0d", k),   {31'd0, o_out[k]},  {31'd0, exp_out(k)});
                chk($sformatf("done%0d", k),  {31'd0, o_done[k]}, {31'd0, exp_done(k)});
                chk($sformatf("busy%0d", k),  {31'd0, o_busy[k]}, {31'd0, q[k].size() != 0});
                chk($sformatf("ready%0d", k), {31'd0, o_rdy[k]},  {31'd0, q[k].size() == 0});
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d);
        int start;
        int waited;
        start  = acc_cnt[k];
        vld[k] = 1'b1;
        dat[k] = d;
        waited = 0;
        while (acc_cnt[k] == start && waited < 100) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("accept_wait", {31'd0, acc_cnt[k] == start}, 32'd0);
    endtask

    task automatic capture(input int k, input int n, output logic [31:0] ov, output logic [31:0] dv);
        ov = '0;
        dv = '0;
        repeat (n) begin
            @(negedge clk);
            ov = {ov[30:0], o_out[k]};
            dv = {dv[30:0], o_done[k]};
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ov, dv;
        logic [31:0] e4;
        int          first_acc;
        acc_cnt = '{0, 0};
        acc_cyc = '{0, 0};
        rst     = 1'b0;
        vld     = 2'b00;
        dat[0]  = 8'h00;
        dat[1]  = 8'h00;

        // Reset held three cycles
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out", {31'd0, out0}, 32'd0);
            chk("rst_ready", {31'd0, o_rdy[0]}, 32'd1);
            chk("rst_busy", {31'd0, busy0}, 32'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single frame 8'hA5
        send(0, 8'hA5);
        vld[0] = 1'b0;
        capture(0, FB, ov, dv);
`ifdef SEQ_TX_PARITY_EN
        chk("a5_bits", ov, 32'h174A);
`else
        chk("a5_bits", ov, 32'h0BA5);
`endif
        chk("a5_done", dv, 32'h1);
        repeat (2) begin
            @(negedge clk);
            chk("a5_gap_out", {31'd0, out0}, 32'd0);
            chk("a5_gap_busy", {31'd0, busy0}, 32'd1);
        end
        @(negedge clk);
        chk("a5_ready_after", {31'd0, o_rdy[0]}, 32'd1);
        chk("a5_busy_after", {31'd0, busy0}, 32'd0);

        // in_valid held: FF then 00
        send(0, 8'hFF);
        first_acc = acc_cyc[0];
        send(0, 8'h00);
        vld[0] = 1'b0;
        chk("held_period", acc_cyc[0] - first_acc, FB + 3);
        repeat (FB + 4) @(negedge clk);

        // GAP_CYCLES=0 back-to-back 8'h81, 8'h7E
        send(1, 8'h81);
        first_acc = acc_cyc[1];
        dat[1] = 8'h7E;
        capture(1, 2 * FB + 1, ov, dv);
        vld[1] = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        e4 = 32'({4'hB, 8'h81, 1'b0, 1'b0, 4'hB, 8'h7E, 1'b0});
`else
        e4 = 32'({4'hB, 8'h81, 1'b0, 4'hB, 8'h7E});
`endif
        chk("b2b_bits", ov, e4);
        chk("b2b_done", dv, (32'd1 << (FB + 1)) | 32'd1);
        chk("b2b_period", acc_cyc[1] - first_acc, FB + 1);
        repeat (FB + 2) @(negedge clk);

        // Reset mid-frame of 8'hC3
        send(0, 8'hC3);
        vld[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out", {31'd0, out0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_ready", {31'd0, o_rdy[0]}, 32'd1);
        send(0, 8'h3C);
        vld[0] = 1'b0;
        capture(0, FB, ov, dv);
`ifdef SEQ_TX_PARITY_EN
        chk("post_abort_bits", ov, 32'h1678);
`else
        chk("post_abort_bits", ov, 32'h0B3C);
`endif
        chk("post_abort_done", dv, 32'h1);
        repeat (4) @(negedge clk);

        // Odd-weight payload 8'h07
        send(0, 8'h07);
        vld[0] = 1'b0;
        capture(0, FB, ov, dv);
`ifdef SEQ_TX_PARITY_EN
        chk("p07_bits", ov, 32'h160F);
`else
        chk("p07_bits", ov, 32'h0B07);
`endif
        chk("p07_done", dv, 32'h1);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
